// File: rtl/mem_sram_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller.
//   - controller state encoding (IDLE / ACC_LO / ACC_HI / DONE)
//   - default wait-state count and the byte address where SRAM starts
//   - SRAM address / data widths and the wait-counter width
package mem_sram_ctrl_pkg;

  localparam int          SRAM_AW         = 18;
  localparam int          SRAM_DW         = 16;
  localparam int          CNT_W           = 4;
  localparam int          WAIT_CYCLES_DEF = 2;
  localparam logic [31:0] MEM_BASE_DEF    = 32'd1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACC_LO = 2'd1,
    ST_ACC_HI = 2'd2,
    ST_DONE   = 2'd3
  } sram_state_e;

endpackage

// File: rtl/mem_sram_ctrl.sv
// MEM-stage controller bridging a 32-bit load/store port onto a 16-bit
// asynchronous SRAM. Each access is two halfword transfers (low half at
// the even halfword address, high half at the odd one), each held for
// WAIT_CYCLES clocks, followed by one DONE cycle.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   rd_en, wr_en      load / store request (both high -> store)
//   address           byte address; SRAM halfword 0 sits at MEM_BASE
//   write_data        store data
//   read_data         registered load result, held until the next load
//   ready             access complete or idle; pipeline freeze = !ready
//   sram_addr         SRAM halfword address
//   sram_dq_out/_in   SRAM data bus, write / read direction
//   sram_dq_oe        controller drives the data bus
//   sram_we_n         SRAM write strobe, active-low
//   dbg_state         current controller state (sram_state_e encoding)
//
// Handshake: the requester raises rd_en/wr_en together with address and
// write_data and keeps all of them stable while ready is low. ready drops
// combinationally in the request cycle and rises again in the DONE cycle;
// a request still present in DONE is ignored, and one present in the
// following IDLE cycle starts a fresh access.
module mem_sram_ctrl
  import mem_sram_ctrl_pkg::*;
#(
  parameter int          WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter logic [31:0] MEM_BASE    = MEM_BASE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic [1:0]         dbg_state
);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] ACC_LO = ST_ACC_LO;
  localparam logic [1:0] ACC_HI = ST_ACC_HI;
  localparam logic [1:0] DONE   = ST_DONE;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_write;
  logic [31:0]      r_read_data;

  logic [31:0]      w_offset;
  logic             w_last;
  logic             w_acc;
  logic             w_drive;
  logic             w_unused_offset;

  // Offset wraps in 32 bits; only bits [18:2] select the word.
  assign w_offset        = address - MEM_BASE;
  assign w_unused_offset = ^{w_offset[31:19], w_offset[1:0]};

  assign w_last  = (r_cnt == CNT_LAST);
  assign w_acc   = (r_state == ACC_LO) || (r_state == ACC_HI);
  assign w_drive = w_acc && r_is_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_is_write  <= 1'b0;
      r_read_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (rd_en || wr_en) begin
            r_state    <= ACC_LO;
            r_cnt      <= '0;
            r_is_write <= wr_en;
          end
        end
        ACC_LO: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= ACC_HI;
            if (!r_is_write) r_read_data[15:0] <= sram_dq_in;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ACC_HI: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= DONE;
            if (!r_is_write) r_read_data[31:16] <= sram_dq_in;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ready       = (r_state == DONE) || ((r_state == IDLE) && !rd_en && !wr_en);
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = w_drive;
    sram_we_n   = !w_drive;
    if (w_acc) begin
      sram_addr = {w_offset[18:2], (r_state == ACC_HI)};
    end
    if (w_drive) begin
      sram_dq_out = (r_state == ACC_HI) ? write_data[31:16] : write_data[15:0];
    end
  end

  assign read_data = r_read_data;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: two instances (WAIT_CYCLES 2 and 1) share the
// request inputs; a select picks which one drives the SRAM model and is
// checked. Expected outputs come from a per-access timeline model.
module tb_mem_sram_ctrl;
  import mem_sram_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rd_en, wr_en;
  logic [31:0] address, write_data;
  logic [15:0] dq_in;
  logic        sel;
  int          cur_w;

  logic [31:0] d0_rd, d1_rd;
  logic        d0_ready, d1_ready, d0_oe, d1_oe, d0_we_n, d1_we_n;
  logic [17:0] d0_addr, d1_addr;
  logic [15:0] d0_dq, d1_dq;
  logic [1:0]  d0_st, d1_st;

  mem_sram_ctrl #(.WAIT_CYCLES(2), .MEM_BASE(32'd1024)) dut0 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(d0_rd), .ready(d0_ready),
    .sram_addr(d0_addr), .sram_dq_out(d0_dq), .sram_dq_in(dq_in),
    .sram_dq_oe(d0_oe), .sram_we_n(d0_we_n), .dbg_state(d0_st)
  );

  mem_sram_ctrl #(.WAIT_CYCLES(1), .MEM_BASE(32'd1024)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(d1_rd), .ready(d1_ready),
    .sram_addr(d1_addr), .sram_dq_out(d1_dq), .sram_dq_in(dq_in),
    .sram_dq_oe(d1_oe), .sram_we_n(d1_we_n), .dbg_state(d1_st)
  );

  logic [31:0] m_rd;
  logic        m_ready, m_oe, m_we_n;
  logic [17:0] m_addr;
  logic [15:0] m_dq;
  logic [1:0]  m_st;
  assign m_rd    = sel ? d1_rd    : d0_rd;
  assign m_ready = sel ? d1_ready : d0_ready;
  assign m_oe    = sel ? d1_oe    : d0_oe;
  assign m_we_n  = sel ? d1_we_n  : d0_we_n;
  assign m_addr  = sel ? d1_addr  : d0_addr;
  assign m_dq    = sel ? d1_dq    : d0_dq;
  assign m_st    = sel ? d1_st    : d0_st;

  // ---------------- SRAM model and reference memory ----------------
  bit [15:0] sram_mem [0:262143];
  bit [15:0] exp_mem  [0:262143];
  assign dq_in = sram_mem[m_addr];
  always @(posedge clk) if (!m_we_n) sram_mem[m_addr] <= m_dq;

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        chk_en;
  logic        exp_ready, exp_oe, exp_we_n;
  logic [17:0] exp_addr;
  logic [15:0] exp_dq;
  logic [31:0] exp_rd;
  logic [1:0]  exp_state;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready",     32'(m_ready), 32'(exp_ready));
      chk("sram_addr", 32'(m_addr),  32'(exp_addr));
      chk("dq_out",    32'(m_dq),    32'(exp_dq));
      chk("dq_oe",     32'(m_oe),    32'(exp_oe));
      chk("we_n",      32'(m_we_n),  32'(exp_we_n));
      chk("read_data", m_rd,         exp_rd);
      chk("state",     32'(m_st),    32'(exp_state));
    end
  end

  task automatic exp_idle();
    exp_addr  = '0;
    exp_dq    = '0;
    exp_oe    = 1'b0;
    exp_we_n  = 1'b1;
    exp_state = ST_IDLE;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0;
      address = $urandom; write_data = $urandom;
      exp_idle();
      exp_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
    exp_idle(); exp_ready = 1'b1; exp_rd = '0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One access on the timeline k = 0 (request in IDLE) .. 2w+1 (DONE).
  // keep: leave the request up during DONE. rst_at: assert reset at that k.
  task automatic access(input bit do_rd, input bit do_wr, input logic [31:0] a,
                        input logic [31:0] d, input bit keep, input int rst_at,
                        output int low_cnt);
    int          w;
    logic [31:0] off;
    logic [16:0] idx;
    logic [17:0] lo, hi;
    bit          iswr;
    w    = cur_w;
    off  = a - MEM_BASE_DEF;
    idx  = 17'((off >> 2) & 32'h1_FFFF);
    lo   = {idx, 1'b0};
    hi   = {idx, 1'b1};
    iswr = do_wr;
    low_cnt = 0;
    for (int k = 0; k <= 2 * w + 1; k++) begin
      @(posedge clk); #1;
      if (k == 2 * w + 1 && !keep) begin
        rd_en = 1'b0; wr_en = 1'b0; address = $urandom; write_data = $urandom;
      end else begin
        rd_en = do_rd; wr_en = do_wr; address = a; write_data = d;
      end
      // halves complete at the end of their last wait cycle
      if (k == w + 1) begin
        if (iswr) exp_mem[lo] = d[15:0]; else exp_rd[15:0] = exp_mem[lo];
      end
      if (k == 2 * w + 1) begin
        if (iswr) exp_mem[hi] = d[31:16]; else exp_rd[31:16] = exp_mem[hi];
      end
      exp_idle();
      exp_ready = 1'b0;
      if (k >= 1 && k <= 2 * w) begin
        exp_addr  = (k <= w) ? lo : hi;
        exp_state = (k <= w) ? ST_ACC_LO : ST_ACC_HI;
        exp_we_n  = !iswr;
        exp_oe    = iswr;
        exp_dq    = iswr ? ((k <= w) ? d[15:0] : d[31:16]) : 16'h0;
      end
      if (k == 2 * w + 1) begin
        exp_ready = 1'b1;
        exp_state = ST_DONE;
      end
      if (k == rst_at) begin
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
        exp_idle(); exp_ready = 1'b1; exp_rd = '0;
      end
      @(negedge clk);
      if (!m_ready) low_cnt++;
      if (k == rst_at) begin
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        break;
      end
    end
  endtask

  task automatic random_ops(input int n);
    int          op, lc;
    bit          keep;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      op   = $urandom_range(0, 3);
      keep = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = MEM_BASE_DEF + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
      access(op != 2, op >= 2, a, $urandom, keep, -1, lc);
      chk("rand_latency", 32'(lc), 32'(2 * cur_w + 1));
      if (!keep) idle_cycles($urandom_range(0, 2));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int          lc;
    logic [31:0] v;
    rst = 1'b0; sel = 1'b0; cur_w = 2; chk_en = 1'b0;
    rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    #1 rst = 1'b1;
    for (int i = 0; i < 262144; i++) begin
      v = $urandom;
      sram_mem[i] = v[15:0];
      exp_mem[i]  = v[15:0];
    end
    sram_mem[2] = 16'h5678; exp_mem[2] = 16'h5678;
    sram_mem[3] = 16'h1234; exp_mem[3] = 16'h1234;

    // reset state: idle, ready only without a request
    exp_idle(); exp_ready = 1'b1; exp_rd = '0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rd_en = 1'b1; exp_ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0; rd_en = 1'b0; exp_ready = 1'b1;
    @(negedge clk);

    // write 0xDEADBEEF to 1024
    access(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 1'b0, -1, lc);
    chk("wr_latency", 32'(lc), 32'd5);
    chk("wr_mem0", 32'(sram_mem[0]), 32'h0000_BEEF);
    chk("wr_mem1", 32'(sram_mem[1]), 32'h0000_DEAD);
    chk("model_mem1", 32'(exp_mem[1]), 32'h0000_DEAD);
    idle_cycles(1);

    // read 1028 -> halfwords 2,3
    access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, -1, lc);
    chk("rd_latency", 32'(lc), 32'd5);
    chk("rd_value", m_rd, 32'h1234_5678);
    chk("model_rd", exp_rd, 32'h1234_5678);
    idle_cycles(2);

    // both enables: a write, read_data untouched
    access(1'b1, 1'b1, 32'd1032, 32'hA5A5_0F0F, 1'b0, -1, lc);
    chk("both_keep_rd", m_rd, 32'h1234_5678);
    chk("both_mem4", 32'(sram_mem[4]), 32'h0000_0F0F);
    chk("both_mem5", 32'(sram_mem[5]), 32'h0000_A5A5);
    idle_cycles(1);

    // reset in the first ACC_HI cycle of a write, then read the same word
    access(1'b0, 1'b1, 32'd1036, 32'h1122_3344, 1'b0, 3, lc);
    chk("rst_rd_zero", m_rd, 32'h0);
    access(1'b1, 1'b0, 32'd1036, 32'h0, 1'b0, -1, lc);
    chk("partial_lo", 32'(m_rd[15:0]), 32'h0000_3344);
    idle_cycles(1);

    // back-to-back reads with the request held through DONE
    access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, -1, lc);
    access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, -1, lc);
    chk("b2b_latency", 32'(lc), 32'd5);
    chk("b2b_value", m_rd, 32'h1234_5678);
    idle_cycles(1);

    random_ops(40);
    idle_cycles(1);

    // switch to the single-wait-state instance
    @(posedge clk); #1;
    sel = 1'b1; cur_w = 1;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
    exp_idle(); exp_ready = 1'b1; exp_rd = '0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);

    access(1'b0, 1'b1, 32'd1024 + 32'h7_FFFC, 32'hCAFE_F00D, 1'b0, -1, lc);
    chk("w1_latency", 32'(lc), 32'd3);
    chk("w1_mem_lo", 32'(sram_mem[18'h3FFFE]), 32'h0000_F00D);
    chk("w1_mem_hi", 32'(sram_mem[18'h3FFFF]), 32'h0000_CAFE);
    access(1'b1, 1'b0, 32'd1024 + 32'h7_FFFC, 32'h0, 1'b0, -1, lc);
    chk("w1_rd_value", m_rd, 32'hCAFE_F00D);
    idle_cycles(1);

    random_ops(20);
    idle_cycles(2);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
